serial_adder: RTL
=================

SERIAL_ADDER -- requirements
Module: serial_adder

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, giving the operand and sum width in bits (legal range 2..32).
REQ-002 The block SHALL have port sys_clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port sys_rst, input, 1 bit: reset, synchronous and active-high.
REQ-004 The block SHALL have port in_valid, input, 1 bit: operands a, b and cin are valid.
REQ-005 The block SHALL have port in_ready, output, 1 bit: the block accepts operands.
REQ-006 The block SHALL have port a, input, WIDTH bits: first operand.
REQ-007 The block SHALL have port b, input, WIDTH bits: second operand.
REQ-008 The block SHALL have port cin, input, 1 bit: carry-in to bit 0.
REQ-009 The block SHALL have port out_valid, output, 1 bit: sum and cout are valid.
REQ-010 The block SHALL have port out_ready, input, 1 bit: the downstream consumer takes the result.
REQ-011 The block SHALL have port sum, output, WIDTH bits: the result sum.
REQ-012 The block SHALL have port cout, output, 1 bit: carry-out of the MSB.
REQ-013 The block SHALL have port busy, output, 1 bit: high in SHIFT.

Function
REQ-014 The block SHALL compute a+b+cin bit-serially, LSB first, one bit per cycle, through a single instance of the team's one-bit full_adder cell.
REQ-015 The FSM SHALL have three states: IDLE, SHIFT and DONE.
REQ-016 IDLE SHALL assert in_ready=1; DONE and SHIFT SHALL drive in_ready=0.
REQ-017 IDLE SHALL, when in_valid&&in_ready is high at an edge, latch a, b and cin into shift registers and the carry flop, clear the bit counter to 0, and go to SHIFT.
REQ-018 SHIFT SHALL, at each edge: feed operand LSBs plus the carry flop to the full_adder; shift the sum bit into the MSB of the sum register (right shift); load the carry flop with the cell's cout; shift both operand registers right; increment the counter.
REQ-019 SHIFT SHALL go to DONE at the edge where the counter reaches WIDTH-1; SHIFT therefore lasts exactly WIDTH cycles.
REQ-020 Latency SHALL be: accept at edge T, then out_valid=1 after edge T+WIDTH.
REQ-021 DONE SHALL hold out_valid=1 with sum and cout stable until out_ready=1 at an edge, then go to IDLE.
REQ-022 The block SHALL support full throughput of one result per WIDTH+2 cycles; it SHALL NOT accept new input in the cycle that the output handshake completes.
REQ-023 The block SHALL ignore in_valid outside IDLE; no input is queued.
REQ-024 The block SHALL keep sum and cout unchanged from the DONE handshake until the next completion.
REQ-025 The block SHALL treat arithmetic as modulo 2^WIDTH in sum, with the (WIDTH+1)th bit in cout.

Reset
REQ-026 When sys_rst=1 at an edge, the block SHALL enter IDLE and clear sum, cout, the carry flop, operand registers and counter to 0, giving in_ready=1, out_valid=0 and busy=0 on the next cycle.
REQ-027 Reset asserted in SHIFT or DONE SHALL abort the operation with no out_valid pulse; reset SHALL take priority over in_valid and out_ready in the same cycle.

Configuration
REQ-028 With macro SERIAL_ADDER_OVF_EN defined, the block SHALL add output port ovf (1 bit), the signed overflow equal to the carry into the MSB XOR cout; ovf SHALL be valid with out_valid, reset to 0, and follow the same hold rules as cout.
REQ-029 Without SERIAL_ADDER_OVF_EN, the ovf port and its logic SHALL be absent, with all other behaviour identical.

Verification (WIDTH=8)
REQ-030 The bench SHALL check a=0x0F, b=0x01, cin=0 -> sum=0x10, cout=0, with out_valid rising exactly 8 cycles after accept.
REQ-031 The bench SHALL check a=0xFF, b=0x00, cin=1 -> sum=0x00, cout=1; with the macro, ovf=0.
REQ-032 With the macro, the bench SHALL check a=0x7F, b=0x01, cin=0 -> sum=0x80, cout=0, ovf=1.
REQ-033 The bench SHALL hold out_ready=0 for 5 cycles in DONE and check that out_valid, sum and cout stay stable, in_ready=0, and an in_valid pulse is ignored; after out_ready=1, the block SHALL return to IDLE.
REQ-034 The bench SHALL assert sys_rst during the 4th SHIFT cycle and check IDLE next cycle, all outputs 0, no out_valid, and that a following 0x55+0xAA cin=0 gives 0xFF, cout=0.
REQ-035 The bench SHALL apply 200 random back-to-back transactions with random out_ready stalls and compare against a+b+cin reference model results.

Source files
------------

// File: rtl/serial_adder.sv
// Bit-serial adder: a+b+cin, LSB first, one bit per clock through one full_adder.
// Define SERIAL_ADDER_OVF_EN to add the signed-overflow output ovf.

module full_adder (
   input  logic a,
   input  logic b,
   input  logic cin,
   output logic sum,
   output logic cout
);
   assign sum  = a ^ b ^ cin;
   assign cout = (a & b) | (cin & (a ^ b));
endmodule

module serial_adder #(
   parameter int WIDTH = 8
) (
   input  logic             sys_clk,
   input  logic             sys_rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] sum,
   output logic             cout,
   output logic             busy
`ifdef SERIAL_ADDER_OVF_EN
   ,
   output logic             ovf
`endif
);

   localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

   typedef enum logic [1:0] {
      IDLE,
      SHIFT,
      DONE
   } state_t;

   state_t state, state_n;

   logic [WIDTH-1:0] a_sr, b_sr;
   logic [WIDTH-2:0] sum_sr;
   logic [WIDTH-1:0] sum_nx;
   logic [CW-1:0]    cnt;
   logic             carry;
   logic             fa_s, fa_c;
   logic             last;

   full_adder fa (
      .a    (a_sr[0]),
      .b    (b_sr[0]),
      .cin  (carry),
      .sum  (fa_s),
      .cout (fa_c)
   );

   // Partial sum keeps only the top WIDTH-1 bits; the final bit completes it.
   assign sum_nx = {fa_s, sum_sr};
   assign last   = (cnt == CW'(WIDTH - 1));

   always_ff @(posedge sys_clk) begin
      if (sys_rst) state <= IDLE;
      else         state <= state_n;
   end

   always_comb begin
      state_n   = state;
      in_ready  = 1'b0;
      out_valid = 1'b0;
      busy      = 1'b0;
      unique case (state)
         IDLE: begin
            in_ready = 1'b1;
            if (in_valid) state_n = SHIFT;
         end
         SHIFT: begin
            busy = 1'b1;
            if (last) state_n = DONE;
         end
         DONE: begin
            out_valid = 1'b1;
            if (out_ready) state_n = IDLE;
         end
         default: state_n = IDLE;
      endcase
   end

   always_ff @(posedge sys_clk) begin
      if (sys_rst) begin
         a_sr   <= '0;
         b_sr   <= '0;
         sum_sr <= '0;
         cnt    <= '0;
         carry  <= 1'b0;
         sum    <= '0;
         cout   <= 1'b0;
`ifdef SERIAL_ADDER_OVF_EN
         ovf    <= 1'b0;
`endif
      end else begin
         unique case (state)
            IDLE: begin
               if (in_valid) begin
                  a_sr  <= a;
                  b_sr  <= b;
                  carry <= cin;
                  cnt   <= '0;
               end
            end
            SHIFT: begin
               a_sr   <= a_sr >> 1;
               b_sr   <= b_sr >> 1;
               sum_sr <= sum_nx[WIDTH-1:1];
               carry  <= fa_c;
               cnt    <= cnt + 1'b1;
               // Outputs only move on completion so they hold between results.
               if (last) begin
                  sum  <= sum_nx;
                  cout <= fa_c;
`ifdef SERIAL_ADDER_OVF_EN
                  ovf  <= carry ^ fa_c;
`endif
               end
            end
            default: ;
         endcase
      end
   end

endmodule
